rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Reset sequencer for the processing system. Sits on the system clock and drives the active-low asynchronous reset inputs of each domain's 2-stage reset synchronizer.
- Holds all domains in reset for a minimum width, then releases them one at a time in index order.
- Before releasing the next domain, waits for the current domain's synchronized "out of reset" indication to return, or for a timeout.
- Offers a software reset request/acknowledge handshake that re-runs the whole sequence.

Parameters:
- NUM_DOMAINS, 2, number of reset domains sequenced (1..8).
- ASSERT_CYCLES, 16, minimum cycles all dom_rst_n are held low (>=2).
- RELEASE_GAP, 8, idle cycles between one domain's readiness and the next release (>=0).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a domain's ready before giving up (>=4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw_rst_req  in  1  level software reset request; sampled only in RUN.
- sw_rst_ack  out  1  one-cycle pulse accepting a request.
- dom_rdy  in  NUM_DOMAINS  per-domain synchronized reset output, asynchronous to clk; high = domain out of reset.
- dom_rst_n  out  NUM_DOMAINS  registered, active-low reset to each domain's synchronizer.
- all_ready  out  1  high in RUN while every synchronized dom_rdy is high.
- busy  out  1  high in every state except RUN.
- timeout_err  out  1  sticky flag: a domain missed its ready timeout.

Behaviour:
- Reset values while rst=1:
  - state ASSERT, counter 0, domain index 0.
  - dom_rst_n all 0, sw_rst_ack 0, all_ready 0, busy 1, timeout_err 0.
  - dom_rdy synchronizer flops cleared to 0.
- dom_rdy sync: each bit passes through a 2-flop synchronizer; rdy_s denotes the synchronized value. The FSM uses only rdy_s.
- One shared counter. Width is $clog2 of the largest of ASSERT_CYCLES, RELEASE_GAP and TIMEOUT_CYCLES, plus 1. The counter saturates, never wraps.
- ASSERT:
  - All dom_rst_n are 0; counter increments each cycle.
  - When counter == ASSERT_CYCLES-1: go to RELEASE, clear the counter, set dom_rst_n[idx]=1.
  - dom_rst_n[0] is therefore first high ASSERT_CYCLES clocks after the first edge with rst=0.
- RELEASE (waiting for domain idx):
  - If rdy_s[idx]=1: go to GAP and clear the counter.
  - Else if counter == TIMEOUT_CYCLES-1: set timeout_err, go to GAP, clear the counter. dom_rst_n[idx] stays 1.
  - Else the counter increments.
- GAP:
  - Counts RELEASE_GAP cycles; RELEASE_GAP=0 means a single pass-through cycle.
  - Then, if idx == NUM_DOMAINS-1: go to RUN.
  - Otherwise: idx+1, set dom_rst_n[idx+1]=1, go to RELEASE.
- Released domains stay released; domains are never released out of index order.
- RUN:
  - busy=0; all_ready = AND of rdy_s.
  - A domain whose rdy_s drops causes all_ready=0, with no automatic re-sequence.
  - On sw_rst_req=1: pulse sw_rst_ack for exactly one cycle, drive all dom_rst_n=0 on the same edge, clear timeout_err, reset idx and counter, go to ASSERT.
- sw_rst_req outside RUN: ignored; no ack is produced.
  - A request still held when RUN is reached is accepted in the first RUN cycle.
  - A held request therefore loops the sequence; requesters must drop req after the ack.
- rst=1 in any state, mid-sequence included, forces the reset values on the next edge. Nothing is remembered.
- rdy_s[idx] already high on entry to RELEASE: advance to GAP on the next edge (one-cycle RELEASE).
- Ready and timeout on the same cycle: ready wins; timeout_err is not set.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum {ASSERT, RELEASE, GAP, RUN};
  - the counter-width function;
  - default parameter constants.
- Sub-module bit_sync: a 2-flop, parameterised-width synchronizer with synchronous active-high clear, instantiated once for dom_rdy.

Test Plan:
- Power-up: rst high for 5 cycles, then low; model raises dom_rdy[k] 3 cycles after dom_rst_n[k] rises.
  - dom_rst_n=2'b00 for exactly 16 clocks.
  - dom_rst_n[0] rises, then dom_rst_n[1] rises 8+sync+1 cycles after dom_rdy[0].
  - all_ready=1, busy=0, timeout_err=0.
- Timeout: dom_rdy[0] tied 0.
  - dom_rst_n[1] rises 64+8 (+fixed offset) cycles after dom_rst_n[0].
  - timeout_err=1 and stays 1 in RUN.
  - all_ready=0.
- Software reset: in RUN, assert sw_rst_req for 1 cycle.
  - sw_rst_ack is high for exactly 1 cycle.
  - dom_rst_n=0 on the same edge.
  - Full sequence repeats; timeout_err cleared.
- Request during sequencing: sw_rst_req pulsed while in RELEASE.
  - No ack; sequence unaffected.
  - Held req is acked in the first RUN cycle.
- Reset mid-sequence: rst high for 1 cycle while in GAP (dom_rst_n=2'b01).
  - Next edge: dom_rst_n=2'b00, busy=1.
  - Restart takes exactly 16 ASSERT cycles.
- Domain drop in RUN: deassert dom_rdy[1].
  - all_ready falls 2-3 cycles later; dom_rst_n unchanged; busy stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, default
// parameters and the shared-counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    GAP     = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int DEF_NUM_DOMAINS    = 2;
  localparam int DEF_ASSERT_CYCLES  = 16;
  localparam int DEF_RELEASE_GAP    = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // One counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int r, input int t);
    int m;
    m = a;
    if (r > m) m = r;
    if (t > m) m = t;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_bit_sync.sv
// Two-flop synchronizer, parameterised width, with synchronous active-high clear.
// Latency: two i_clk edges from i_d to o_q.
module bit_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds every domain in reset, then releases them in index
// order, waiting for each synchronized ready (or a timeout) before the next.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
  parameter int RELEASE_GAP    = DEF_RELEASE_GAP,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sw_rst_req,
  output logic                   o_sw_rst_ack,
  input  logic [NUM_DOMAINS-1:0] i_dom_rdy,
  output logic [NUM_DOMAINS-1:0] o_dom_rst_n,
  output logic                   o_all_ready,
  output logic                   o_busy,
  output logic                   o_timeout_err
);

  localparam int CW = cnt_width(ASSERT_CYCLES, RELEASE_GAP, TIMEOUT_CYCLES);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] ASSERT_LAST  = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  // A zero gap still spends one cycle in GAP.
  localparam logic [CW-1:0] GAP_LAST     = CW'((RELEASE_GAP == 0) ? 0 : RELEASE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DOMAINS - 1);

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic                   r_sw_rst_ack;
  logic                   r_all_ready;
  logic                   r_busy;
  logic                   r_timeout_err;

  logic [NUM_DOMAINS-1:0] w_rdy_s;
  logic [CW-1:0]          w_cnt_inc;
  logic [IW-1:0]          w_idx_nxt;
  logic                   w_rdy_cur;
  logic                   w_all_rdy;

  bit_sync #(
    .WIDTH (NUM_DOMAINS)
  ) u_rdy_sync (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_d   (i_dom_rdy),
    .o_q   (w_rdy_s)
  );

  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_idx_nxt = r_idx + IW'(1);
  assign w_rdy_cur = w_rdy_s[r_idx];
  assign w_all_rdy = &w_rdy_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ASSERT;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_dom_rst_n   <= '0;
      r_sw_rst_ack  <= 1'b0;
      r_all_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      r_sw_rst_ack <= 1'b0;
      case (r_state)
        ASSERT: begin
          r_dom_rst_n <= '0;
          r_all_ready <= 1'b0;
          r_busy      <= 1'b1;
          if (r_cnt == ASSERT_LAST) begin
            r_state            <= RELEASE;
            r_cnt              <= '0;
            r_dom_rst_n[r_idx] <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        RELEASE: begin
          // Ready is tested first so it wins over a coincident timeout.
          if (w_rdy_cur) begin
            r_state <= GAP;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state       <= GAP;
            r_cnt         <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_state     <= RUN;
              r_busy      <= 1'b0;
              r_all_ready <= w_all_rdy;
            end else begin
              r_state                <= RELEASE;
              r_idx                  <= w_idx_nxt;
              r_dom_rst_n[w_idx_nxt] <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        RUN: begin
          if (i_sw_rst_req) begin
            r_state       <= ASSERT;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_dom_rst_n   <= '0;
            r_sw_rst_ack  <= 1'b1;
            r_all_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
          end else begin
            r_all_ready <= w_all_rdy;
          end
        end

        default: begin
          r_state <= ASSERT;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign o_dom_rst_n   = r_dom_rst_n;
  assign o_sw_rst_ack  = r_sw_rst_ack;
  assign o_all_ready   = r_all_ready;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: timing of each release is predicted from
// per-domain ready delays with plain arithmetic and compared to observed edges.
module tb_rst_seq;

  localparam int N = 2;
  localparam int A = 16;
  localparam int G = 8;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [N-1:0] dom_rdy = '0;
  logic         ack;
  logic [N-1:0] dom_rst_n;
  logic         all_ready;
  logic         busy;
  logic         to_err;

  rst_seq #(
    .NUM_DOMAINS    (N),
    .ASSERT_CYCLES  (A),
    .RELEASE_GAP    (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sw_rst_req  (req),
    .o_sw_rst_ack  (ack),
    .i_dom_rdy     (dom_rdy),
    .o_dom_rst_n   (dom_rst_n),
    .o_all_ready   (all_ready),
    .o_busy        (busy),
    .o_timeout_err (to_err)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           ack_cnt = 0;
  int           rise_cyc [N];
  int           dly [N];
  logic [N-1:0] frc = '0;
  logic [N-1:0] prev_rst_n = '0;

  // Edge monitor and domain responder: each domain raises ready dly[k]
  // cycles after its reset is released (dly < 0 means never) and drops it
  // as soon as reset returns or the bench forces it low.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (dom_rst_n[k] && !prev_rst_n[k]) rise_cyc[k] = cyc;
    end
    prev_rst_n = dom_rst_n;
    if (ack) ack_cnt++;
    for (int k = 0; k < N; k++) begin
      if (!dom_rst_n[k] || frc[k]) dom_rdy[k] = 1'b0;
      else if (dly[k] >= 0 && (cyc - rise_cyc[k]) == dly[k]) dom_rdy[k] = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: edge offset from a domain's release to its RELEASE exit.
  function automatic int rel_span(input int d);
    if (d < 0 || d + 3 > T) return T;
    return d + 3;
  endfunction

  function automatic int timed_out(input int d);
    return (d < 0 || d + 3 > T) ? 1 : 0;
  endfunction

  function automatic int gap_len();
    return (G == 0) ? 1 : G;
  endfunction

  task automatic wait_run(input string name, output int runc);
    runc = -1;
    for (int i = 0; i < 600; i++) begin
      if (!busy) begin
        runc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (runc < 0) chk({name, "_run_timeout"}, 0, 1);
  endtask

  task automatic wait_rise0(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (dom_rst_n[0]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) chk({name, "_rise0_timeout"}, 0, 1);
  endtask

  // Called at a negedge while in RUN; returns the edge that produced the ack.
  task automatic sw_reset(input string name, output int ack_edge);
    int a0;
    a0  = ack_cnt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    ack_edge = cyc;
    chk({name, "_ack_hi"}, int'(ack), 1);
    chk({name, "_rstn_low"}, int'(dom_rst_n), 0);
    chk({name, "_to_clr"}, int'(to_err), 0);
    @(negedge clk);
    chk({name, "_ack_lo"}, int'(ack), 0);
    chk({name, "_ack_width"}, ack_cnt - a0, 1);
  endtask

  task automatic run_seq(input string name, input int d0, input int d1,
                         input int e_g1, input int e_run, input int e_to, input int e_ar);
    int ae, runc;
    dly[0] = d0;
    dly[1] = d1;
    sw_reset(name, ae);
    wait_run(name, runc);
    chk({name, "_assert_len"}, rise_cyc[0] - ae, A);
    chk({name, "_rel1"}, rise_cyc[1] - rise_cyc[0], e_g1);
    chk({name, "_run"}, runc - rise_cyc[1], e_run);
    chk({name, "_to"}, int'(to_err), e_to);
    chk({name, "_rstn"}, int'(dom_rst_n), 3);
    if (e_ar >= 0) chk({name, "_all_rdy"}, int'(all_ready), e_ar);
    repeat (5) @(negedge clk);
    chk({name, "_to_hold"}, int'(to_err), e_to);
  endtask

  typedef struct {
    string name;
    int    d0;
    int    d1;
    int    e_g1;
    int    e_run;
    int    e_to;
    int    e_ar;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   rel, runc, ae, a0, ackc, fall, c0, d0, d1;

    vecs[0] = '{"fast",      3,  3, 14, 14, 0, 1};
    vecs[1] = '{"tie0",     61,  3, 72, 14, 0, 1};
    vecs[2] = '{"late0",    62,  3, 72, 14, 1, 1};
    vecs[3] = '{"dead0",    -1,  3, 72, 14, 1, 0};
    vecs[4] = '{"tie1",      3, 61, 14, 72, 0, 1};
    vecs[5] = '{"dead1",     3, -1, 14, 72, 1, 0};

    dly[0] = 3;
    dly[1] = 3;

    // Power-up
    repeat (5) @(negedge clk);
    chk("rst_rstn", int'(dom_rst_n), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_all_rdy", int'(all_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_to", int'(to_err), 0);
    rst = 1'b0;
    rel = cyc;
    while (cyc < rel + A - 1) @(negedge clk);
    chk("pu_still_low", int'(dom_rst_n), 0);
    @(negedge clk);
    chk("pu_rise0", int'(dom_rst_n), 1);
    wait_run("pu", runc);
    chk("pu_assert_len", rise_cyc[0] - rel, A);
    chk("pu_rel1", rise_cyc[1] - rise_cyc[0], 3 + 2 + 1 + G);
    chk("pu_run", runc - rise_cyc[1], 14);
    chk("pu_all_rdy", int'(all_ready), 1);
    chk("pu_busy", int'(busy), 0);
    chk("pu_to", int'(to_err), 0);

    // Table of delay corner cases
    for (int v = 0; v < 6; v++)
      run_seq(vecs[v].name, vecs[v].d0, vecs[v].d1, vecs[v].e_g1,
              vecs[v].e_run, vecs[v].e_to, vecs[v].e_ar);

    // Request pulsed during RELEASE is ignored
    dly[0] = 5;
    dly[1] = 3;
    sw_reset("ign", ae);
    wait_rise0("ign");
    repeat (2) @(negedge clk);
    a0  = ack_cnt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_no_ack", ack_cnt - a0, 0);
    wait_run("ign", runc);
    chk("ign_rel1", rise_cyc[1] - rise_cyc[0], 5 + 3 + G);
    chk("ign_run", runc - rise_cyc[1], 14);

    // Held request is accepted in the first RUN cycle
    dly[0] = 3;
    sw_reset("held", ae);
    wait_rise0("held");
    req  = 1'b1;
    runc = -1;
    ackc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && runc < 0) runc = cyc;
      if (ack) begin
        ackc = cyc;
        break;
      end
    end
    req = 1'b0;
    chk("held_ack_seen", (ackc >= 0) ? 1 : 0, 1);
    chk("held_ack_first_run", ackc - runc, 1);
    chk("held_rstn_low", int'(dom_rst_n), 0);
    chk("held_assert_len", rise_cyc[0] > ackc ? 1 : 0, 0);
    wait_run("held2", runc);
    chk("held2_assert_len", rise_cyc[0] - ackc, A);
    chk("held2_all_rdy", int'(all_ready), 1);

    // Synchronous reset in the middle of GAP
    sw_reset("mid", ae);
    wait_rise0("mid");
    c0 = rise_cyc[0];
    while (cyc < c0 + 7) @(negedge clk);
    chk("mid_in_gap", int'(dom_rst_n), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rstn", int'(dom_rst_n), 0);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b0;
    rel = cyc;
    wait_rise0("mid_restart");
    chk("mid_assert_len", rise_cyc[0] - rel, A);
    wait_run("mid", runc);
    chk("mid_all_rdy", int'(all_ready), 1);

    // Domain 1 drops while in RUN
    c0 = cyc;
    frc[1] = 1'b1;
    fall = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!all_ready) begin
        fall = cyc;
        break;
      end
    end
    chk("drop_fall_delay", fall - (c0 + 1), 3);
    chk("drop_rstn", int'(dom_rst_n), 3);
    chk("drop_busy", int'(busy), 0);
    frc[1] = 1'b0;

    // Randomized delays against the arithmetic model
    for (int r = 0; r < 12; r++) begin
      d0 = int'($urandom_range(0, 80));
      d1 = int'($urandom_range(0, 80));
      dly[0] = d0;
      dly[1] = d1;
      sw_reset("rnd", ae);
      wait_run("rnd", runc);
      chk("rnd_assert_len", rise_cyc[0] - ae, A);
      chk("rnd_rel1", rise_cyc[1] - rise_cyc[0], rel_span(d0) + gap_len());
      chk("rnd_run", runc - rise_cyc[1], rel_span(d1) + gap_len());
      chk("rnd_to", int'(to_err), (timed_out(d0) | timed_out(d1)));
      repeat (100) @(negedge clk);
      chk("rnd_all_rdy", int'(all_ready), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
